// File: rtl/button_conditioner_pkg.sv
// Shared types and default timing for the push-button conditioning stage.
// Timing defaults are derived from the 25 MHz vga_clk.
package button_conditioner_pkg;

  localparam int CLK_HZ = 25_000_000;

  localparam int DEF_DEBOUNCE_CYCLES = CLK_HZ / 100;     // 10 ms
  localparam int DEF_REPEAT_DELAY    = CLK_HZ * 3 / 10;  // 300 ms
  localparam int DEF_REPEAT_PERIOD   = CLK_HZ / 10;      // 100 ms
  localparam int DEF_FIRE_LOCKOUT    = CLK_HZ / 5;       // 200 ms
  localparam int DEF_CNT_W           = 23;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_FIRST  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  typedef enum logic {
    F_READY   = 1'b0,
    F_LOCKOUT = 1'b1
  } fire_state_t;

endpackage

// File: rtl/button_conditioner_if.sv
// Raw buttons in, debounced levels and single-cycle events out.
// master = button source / consumer side, slave = the conditioner.
interface button_conditioner_if;
  logic izq_raw;
  logic der_raw;
  logic fire_raw;
  logic izq_level;
  logic der_level;
  logic fire_level;
  logic izq_step;
  logic der_step;
  logic fire_pulse;
  logic fire_ready;

  modport master (
    output izq_raw, der_raw, fire_raw,
    input  izq_level, der_level, fire_level,
    input  izq_step, der_step, fire_pulse, fire_ready
  );

  modport slave (
    input  izq_raw, der_raw, fire_raw,
    output izq_level, der_level, fire_level,
    output izq_step, der_step, fire_pulse, fire_ready
  );
endinterface

// File: rtl/button_conditioner_debounce_channel.sv
// One button channel: 2-flop synchroniser, debounce counter, stable level.
// rise/fall flag the cycle whose clock edge flips the stable level.
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic vga_clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;
  logic             differ;
  logic             settle;

  assign differ = sync_p1 ^ level;
  assign settle = differ && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign rise   = settle & ~level;
  assign fall   = settle &  level;

  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      if (!differ || settle) cnt <= '0;
      else                   cnt <= cnt + 1'b1;
      if (settle) level <= ~level;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: debounced levels, hold-to-repeat move steps
// and a rate-limited fire pulse, all registered in the vga_clk domain.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int FIRE_LOCKOUT    = DEF_FIRE_LOCKOUT,
  parameter int CNT_W           = DEF_CNT_W
) (
  input logic                 vga_clk,
  input logic                 reset,
  button_conditioner_if.slave btn
);

  logic [2:0] raw;
  logic [2:0] lvl;
  logic [2:0] rise;
  logic [2:0] fall;
  logic [1:0] mv_nxt;
  logic       both_held;

  assign raw = {btn.fire_raw, btn.der_raw, btn.izq_raw};

  for (genvar c = 0; c < 3; c++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_chan (
      .vga_clk(vga_clk),
      .reset  (reset),
      .raw    (raw[c]),
      .level  (lvl[c]),
      .rise   (rise[c]),
      .fall   (fall[c])
    );
  end

  // Gate on the levels being registered this edge so step and level agree.
  assign mv_nxt    = (lvl[1:0] | rise[1:0]) & ~fall[1:0];
  assign both_held = mv_nxt[0] & mv_nxt[1];

  rpt_state_t       rstate [2];
  logic [CNT_W-1:0] rcnt   [2];
  logic [1:0]       step_q;

  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        rstate[i] <= RPT_IDLE;
        rcnt[i]   <= '0;
      end
      step_q <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        step_q[i] <= 1'b0;
        if (fall[i]) begin
          rstate[i] <= RPT_IDLE;
          rcnt[i]   <= '0;
        end else begin
          case (rstate[i])
            RPT_IDLE: if (rise[i]) begin
              rstate[i] <= RPT_FIRST;
              rcnt[i]   <= CNT_W'(REPEAT_DELAY - 1);
              step_q[i] <= ~both_held;
            end
            RPT_FIRST, RPT_REPEAT: if (rcnt[i] == '0) begin
              rstate[i] <= RPT_REPEAT;
              rcnt[i]   <= CNT_W'(REPEAT_PERIOD - 1);
              step_q[i] <= ~both_held;
            end else begin
              rcnt[i] <= rcnt[i] - 1'b1;
            end
            default: rstate[i] <= RPT_IDLE;
          endcase
        end
      end
    end
  end

  fire_state_t      fstate;
  logic [CNT_W-1:0] fcnt;
  logic             pulse_q;
  logic             ready_q;

  // ready_q lags fstate by one cycle, so lockout leaves one edge early.
  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      fstate  <= F_READY;
      fcnt    <= '0;
      pulse_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      pulse_q <= 1'b0;
      ready_q <= (fstate == F_READY);
      case (fstate)
        F_READY: if (rise[2]) begin
          fstate  <= F_LOCKOUT;
          fcnt    <= CNT_W'(FIRE_LOCKOUT - 2);
          pulse_q <= 1'b1;
        end
        F_LOCKOUT: if (fcnt == '0) fstate <= F_READY;
                   else            fcnt   <= fcnt - 1'b1;
        default: fstate <= F_READY;
      endcase
    end
  end

  assign btn.izq_level  = lvl[0];
  assign btn.der_level  = lvl[1];
  assign btn.fire_level = lvl[2];
  assign btn.izq_step   = step_q[0];
  assign btn.der_step   = step_q[1];
  assign btn.fire_pulse = pulse_q;
  assign btn.fire_ready = ready_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random button
// activity, checked each cycle against a time-based reference model.
module tb_button_conditioner;

  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;
  localparam int FL  = 8;
  localparam int FL2 = 20;

  logic vga_clk = 1'b0;
  logic reset;

  button_conditioner_if btn_if ();
  button_conditioner_if btn2_if ();

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
    .FIRE_LOCKOUT(FL), .CNT_W(8)
  ) dut (
    .vga_clk(vga_clk), .reset(reset), .btn(btn_if)
  );

  // Long-lockout copy: lets a second press settle while still locked out.
  button_conditioner #(
    .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
    .FIRE_LOCKOUT(FL2), .CNT_W(8)
  ) dut_long (
    .vga_clk(vga_clk), .reset(reset), .btn(btn2_if)
  );

  always #5 vga_clk = ~vga_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: level = raw delayed 2, flipped after DEB agreeing samples;
  // steps and pulses are derived from press times.
  logic       hist [3][DEB+2];
  logic [2:0] m_lvl;
  int         t;
  int         press_t [2];
  bit         fired, fired2;
  int         last_fire, last_fire2;
  logic [1:0] m_step;
  logic       m_pulse, m_ready, m_pulse2, m_ready2;

  task automatic model_reset();
    for (int c = 0; c < 3; c++)
      for (int k = 0; k < DEB + 2; k++) hist[c][k] = 1'b0;
    m_lvl = 3'b000;
    m_step = 2'b00;
    fired = 0; fired2 = 0;
    m_pulse = 0; m_pulse2 = 0;
    m_ready = 1; m_ready2 = 1;
  endtask

  task automatic model_edge(input logic [2:0] raws);
    logic [2:0] rose;
    bit flip;
    int dt;
    t++;
    for (int c = 0; c < 3; c++) begin
      for (int k = DEB + 1; k > 0; k--) hist[c][k] = hist[c][k-1];
      hist[c][0] = raws[c];
      flip = 1;
      for (int k = 2; k <= DEB + 1; k++) if (hist[c][k] == m_lvl[c]) flip = 0;
      rose[c] = flip && !m_lvl[c];
      if (flip) m_lvl[c] = ~m_lvl[c];
    end
    for (int i = 0; i < 2; i++) begin
      if (rose[i]) press_t[i] = t;
      dt = t - press_t[i];
      m_step[i] = m_lvl[i] && (dt == 0 || dt == RD || (dt > RD && (dt - RD) % RP == 0))
                  && !(m_lvl[0] && m_lvl[1]);
    end
    m_pulse = rose[2] && (!fired || t - last_fire >= FL);
    if (m_pulse) begin fired = 1; last_fire = t; end
    m_ready = !(fired && t >= last_fire + 1 && t <= last_fire + FL - 1);
    m_pulse2 = rose[2] && (!fired2 || t - last_fire2 >= FL2);
    if (m_pulse2) begin fired2 = 1; last_fire2 = t; end
    m_ready2 = !(fired2 && t >= last_fire2 + 1 && t <= last_fire2 + FL2 - 1);
  endtask

  // Observations per scenario
  int cyc;
  int izq_step_q[$], der_step_q[$], pulse_q[$], pulse2_q[$];
  int izq_lvl_hi, both_cnt, both_viol;
  int izq_rise_cyc, izq_fall_cyc, ready_rise_cyc, ready_fall_cyc;
  logic prev_izq_lvl = 1'b0, prev_ready = 1'b1;

  task automatic scen_start();
    cyc = 0;
    izq_step_q.delete(); der_step_q.delete(); pulse_q.delete(); pulse2_q.delete();
    izq_lvl_hi = 0; both_cnt = 0; both_viol = 0;
    izq_rise_cyc = -1; izq_fall_cyc = -1; ready_rise_cyc = -1; ready_fall_cyc = -1;
  endtask

  task automatic check_all();
    check("izq_level",  btn_if.izq_level,  m_lvl[0]);
    check("der_level",  btn_if.der_level,  m_lvl[1]);
    check("fire_level", btn_if.fire_level, m_lvl[2]);
    check("izq_step",   btn_if.izq_step,   m_step[0]);
    check("der_step",   btn_if.der_step,   m_step[1]);
    check("fire_pulse", btn_if.fire_pulse, m_pulse);
    check("fire_ready", btn_if.fire_ready, m_ready);
    check("long_fire_pulse", btn2_if.fire_pulse, m_pulse2);
    check("long_fire_ready", btn2_if.fire_ready, m_ready2);
  endtask

  task automatic observe();
    if (btn_if.izq_step) izq_step_q.push_back(cyc);
    if (btn_if.der_step) der_step_q.push_back(cyc);
    if (btn_if.fire_pulse) pulse_q.push_back(cyc);
    if (btn2_if.fire_pulse) pulse2_q.push_back(cyc);
    if (btn_if.izq_level) izq_lvl_hi++;
    if (btn_if.izq_level && !prev_izq_lvl) izq_rise_cyc = cyc;
    if (!btn_if.izq_level && prev_izq_lvl) izq_fall_cyc = cyc;
    if (btn_if.izq_level && btn_if.der_level) begin
      both_cnt++;
      if (btn_if.izq_step || btn_if.der_step) both_viol++;
    end
    if (btn_if.fire_ready && !prev_ready && ready_rise_cyc < 0) ready_rise_cyc = cyc;
    if (!btn_if.fire_ready && prev_ready && ready_fall_cyc < 0) ready_fall_cyc = cyc;
    prev_izq_lvl = btn_if.izq_level;
    prev_ready   = btn_if.fire_ready;
  endtask

  task automatic cycle(input logic [2:0] raws);
    {btn_if.fire_raw, btn_if.der_raw, btn_if.izq_raw}    = raws;
    {btn2_if.fire_raw, btn2_if.der_raw, btn2_if.izq_raw} = raws;
    @(posedge vga_clk);
    cyc++;
    if (reset) model_edge(raws);
    @(negedge vga_clk);
    check_all();
    observe();
  endtask

  task automatic hold(input logic [2:0] raws, input int n);
    for (int i = 0; i < n; i++) cycle(raws);
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_izq_level"},  btn_if.izq_level,  0);
    check({pfx, "_der_level"},  btn_if.der_level,  0);
    check({pfx, "_fire_level"}, btn_if.fire_level, 0);
    check({pfx, "_izq_step"},   btn_if.izq_step,   0);
    check({pfx, "_der_step"},   btn_if.der_step,   0);
    check({pfx, "_fire_pulse"}, btn_if.fire_pulse, 0);
    check({pfx, "_fire_ready"}, btn_if.fire_ready, 1);
    check({pfx, "_long_ready"}, btn2_if.fire_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    int exp_steps [6];
    int first_after;
    int rem [3];
    logic [2:0] r;
    exp_steps = '{6, 16, 19, 22, 25, 28};
    t = 0;
    model_reset();
    {btn_if.fire_raw, btn_if.der_raw, btn_if.izq_raw}    = 3'b000;
    {btn2_if.fire_raw, btn2_if.der_raw, btn2_if.izq_raw} = 3'b000;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2 check_reset_values("por");
    @(negedge vga_clk);
    #2 reset = 1'b1;

    // Glitch of 3 cycles is rejected
    scen_start();
    hold(3'b001, 3);
    hold(3'b000, 12);
    check("glitch_level_cycles", izq_lvl_hi, 0);
    check("glitch_steps", izq_step_q.size(), 0);

    // Press and hold 25 cycles
    scen_start();
    hold(3'b001, 25);
    hold(3'b000, 12);
    check("hold_rise_cycle", izq_rise_cyc, 2 + DEB);
    check("hold_fall_cycle", izq_fall_cyc, 25 + 2 + DEB);
    check("hold_nsteps", izq_step_q.size(), 6);
    for (int i = 0; i < izq_step_q.size() && i < 6; i++)
      check("hold_step_cycle", izq_step_q[i], exp_steps[i]);

    // Conflict: der held, izq joins, izq released
    scen_start();
    hold(3'b010, 20);
    hold(3'b011, 15);
    hold(3'b010, 20);
    hold(3'b000, 12);
    check("conflict_overlap", both_cnt, 15);
    check("conflict_steps", both_viol, 0);
    first_after = -1;
    foreach (der_step_q[i])
      if (first_after < 0 && der_step_q[i] > izq_fall_cyc) first_after = der_step_q[i];
    check("conflict_resume_found", (first_after > 0), 1);
    check("conflict_cadence", (first_after - (2 + DEB + RD)) % RP, 0);

    // Fire lockout: three presses with stable rises at 6, 14, 30
    scen_start();
    hold(3'b100, 4);
    hold(3'b000, 4);
    hold(3'b100, 4);
    hold(3'b000, 12);
    hold(3'b100, 4);
    hold(3'b000, 14);
    check("lock_npulse", pulse_q.size(), 3);
    check("lock_first_pulse", (pulse_q.size() > 0) ? pulse_q[0] : -1, 6);
    check("lock_ready_fall", ready_fall_cyc - 6, 1);
    check("lock_ready_rise", ready_rise_cyc - 6, FL);
    check("long_npulse", pulse2_q.size(), 2);
    check("long_second_pulse", (pulse2_q.size() > 1) ? pulse2_q[1] : -1, 30);

    // Fire held 40 cycles fires once
    scen_start();
    hold(3'b100, 40);
    hold(3'b000, 14);
    check("firehold_npulse", pulse_q.size(), 1);

    // Async reset mid-repeat and mid-lockout
    scen_start();
    hold(3'b001, 12);
    hold(3'b101, 10);
    #2 reset = 1'b0;
    #1 check_reset_values("async");
    model_reset();
    hold(3'b101, 2);
    #2 reset = 1'b1;
    scen_start();
    hold(3'b101, 12);
    check("rst_restep_cycle", (izq_step_q.size() > 0) ? izq_step_q[0] : -1, 2 + DEB);
    check("rst_refire_cycle", (pulse_q.size() > 0) ? pulse_q[0] : -1, 2 + DEB);
    hold(3'b000, 24);

    // Random button activity
    r = 3'b000;
    rem = '{0, 0, 0};
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < 3; c++) begin
        if (rem[c] == 0) begin
          r[c] = ~r[c];
          rem[c] = $urandom_range(1, 24);
        end
        rem[c]--;
      end
      cycle(r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Input-conditioning stage directly upstream of the game top level. It takes the three raw push-buttons (`izq`, `der`, `fire`), synchronises and debounces them, and emits clean single-cycle events:
- movement steps with hold-to-repeat for the gun logic;
- a rate-limited fire pulse for the shot builder.

All outputs are registered in the `vga_clk` domain.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 250000: consecutive stable synchronised cycles required to accept a level change (10 ms at 25 MHz).
- `REPEAT_DELAY`, 7500000: hold time before the first auto-repeat step (300 ms).
- `REPEAT_PERIOD`, 2500000: cycles between auto-repeat steps (100 ms).
- `FIRE_LOCKOUT`, 5000000: cycles after a fire pulse during which new presses are ignored (200 ms).
- `CNT_W`, 23: counter width; must hold the largest of the above.

Ports:
- `vga_clk`  in  1  single clock, 25 MHz.
- `reset`  in  1  asynchronous, active-low reset.
- `izq_raw`, `der_raw`, `fire_raw`  in  1 each  raw buttons, asynchronous, active-high.
- `izq_level`, `der_level`, `fire_level`  out  1 each  debounced stable level.
- `izq_step`, `der_step`  out  1 each  one-cycle move-step pulse.
- `fire_pulse`  out  1  one-cycle shot request.
- `fire_ready`  out  1  high when not in lockout.

## Operation
- Each raw input passes through a 2-flop synchroniser. Synchroniser flops reset to 0.
- Per-channel debounce:
  - The counter increments while the synchronised value differs from the stable level.
  - It clears when the two are equal.
  - When the counter reaches `DEBOUNCE_CYCLES-1` while still differing, the stable level toggles and the counter clears.
  - Any glitch shorter than `DEBOUNCE_CYCLES` is discarded.
- Repeat FSM per move channel, with states IDLE, FIRST, REPEAT:
  - IDLE→FIRST on a stable rising edge. Emit a step and load the delay counter.
  - FIRST→REPEAT after `REPEAT_DELAY` cycles held. Emit a step and load the period counter.
  - REPEAT: emit a step every `REPEAT_PERIOD` cycles.
  - From any state, go to IDLE on a stable falling edge. Counters clear.
- Conflict rule: while `izq_level` and `der_level` are both 1, both step outputs are forced to 0. Both FSMs keep running. On release of one button, the other continues its current schedule.
- Fire FSM, with states READY, LOCKOUT:
  - READY: a stable rising edge on fire emits `fire_pulse` and moves to LOCKOUT.
  - LOCKOUT: count `FIRE_LOCKOUT` cycles, then return to READY. Holding fire never re-fires; a new rising edge is required.
  - A rising edge during LOCKOUT is dropped, not queued.
  - `fire_ready` = (state == READY).
- Reset values: all levels 0, all pulses 0, `fire_ready` 1, all FSMs IDLE/READY, all counters 0.
- Reset assertion mid-operation aborts everything immediately, including during lockout or repeat. After release, a button still held becomes a fresh press after sync+debounce.

## Timing
- Raw edge to `*_level` change: 2 cycles (sync) + `DEBOUNCE_CYCLES` cycles.
- `*_step` / `fire_pulse` assert in the same cycle the stable level rises, for exactly 1 cycle.
- First repeat step: `REPEAT_DELAY` cycles after the initial step. Subsequent steps are spaced exactly `REPEAT_PERIOD` cycles.
- `fire_ready` falls in the cycle after `fire_pulse`. It rises exactly `FIRE_LOCKOUT` cycles after the pulse cycle.
- No combinational path from inputs to outputs.

## Structure
- Shared package holds:
  - FSM state encodings (IDLE/FIRST/REPEAT, READY/LOCKOUT);
  - default timing constants, derived from the 25 MHz `vga_clk`.
- One sub-module, `debounce_channel`, instantiated three times: synchroniser, debounce counter, stable level and rising/falling edge strobes.
- Repeat and fire FSMs live in the top of this block.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3, `FIRE_LOCKOUT`=8.
- Glitch rejection: `izq_raw` high for 3 cycles, then low → `izq_level` stays 0 and no `izq_step`.
- Clean press/hold: `izq_raw` high at cycle 0 and held 25 cycles →
  - `izq_level` high at cycle 6;
  - `izq_step` at cycles 6, 16, 19, 22, 25…;
  - after release, level drops 6 cycles later and steps stop.
- Conflict: `der` stable, then `izq` also pressed → both step outputs 0 while both levels are 1. Releasing `izq` resumes `der` steps on its existing 3-cycle cadence.
- Fire lockout:
  - first fire press → `fire_pulse` once, then `fire_ready` low for 8 cycles;
  - a second press becoming stable inside lockout → no pulse;
  - a press after `fire_ready`=1 → pulse.
- Fire hold: `fire_raw` held 40 cycles → exactly one `fire_pulse`.
- Async reset: assert `reset`=0 mid-repeat and mid-lockout, asynchronously to `vga_clk` → all outputs return to reset values immediately. On release with `izq_raw` still high, `izq_step` occurs 6 cycles after release.
